// File: rtl/pid_pkg.sv
// Shared encodings, default widths and clamp/saturate helpers for the
// multi-channel PID controller.
package pid_pkg;

   typedef enum logic [1:0] {
      CFG_KP   = 2'd0,
      CFG_KI   = 2'd1,
      CFG_KD   = 2'd2,
      CFG_ILIM = 2'd3
   } cfg_sel_e;

   localparam int DEF_DW     = 16;
   localparam int DEF_ACCW   = 48;
   localparam int DEF_GSHIFT = 4;

   // Helpers work on a 64-bit signed container, so operand widths must not exceed 64.
   typedef logic signed [63:0] wide_t;

   function automatic wide_t clamp(input wide_t v, input wide_t lo, input wide_t hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic wide_t sat_hi(input int w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t sat_lo(input int w);
      return -(wide_t'(1) <<< (w - 1));
   endfunction

   function automatic wide_t saturate(input wide_t v, input int w);
      return clamp(v, sat_lo(w), sat_hi(w));
   endfunction

endpackage

// File: rtl/pid_sat_clamp.sv
// Combinational signed clamp of val into [lo, hi]; flag is set whenever the
// value had to be moved. Result may be narrower than the input.
module pid_sat_clamp
   import pid_pkg::*;
#(
   parameter int W  = DEF_ACCW,
   parameter int OW = W
) (
   input  logic signed [W-1:0]  val,
   input  logic signed [W-1:0]  lo,
   input  logic signed [W-1:0]  hi,
   output logic signed [OW-1:0] res,
   output logic                 flag
);

   wide_t val_w;
   wide_t r;

   assign val_w = wide_t'(val);
   assign r     = clamp(val_w, wide_t'(lo), wide_t'(hi));
   assign res   = r[OW-1:0];
   assign flag  = (r != val_w);

endmodule

// File: rtl/pid_mc_controller.sv
// Multi-channel PID controller: per-channel gains and integrator state, a
// 3-stage capture/multiply/accumulate pipeline, and a same-channel hazard stall.
module pid_mc_controller
   import pid_pkg::*;
#(
   parameter int  DW     = DEF_DW,
   parameter int  NCH    = 4,
   parameter int  GSHIFT = DEF_GSHIFT,
   parameter int  ACCW   = DEF_ACCW,
   localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CW-1:0]        in_ch,
   input  logic signed [DW-1:0] error_in,
   input  logic                 cfg_we,
   input  logic [CW-1:0]        cfg_ch,
   input  logic [1:0]           cfg_sel,
   input  logic [DW-1:0]        cfg_data,
   input  logic [NCH-1:0]       clr_int,
   output logic                 out_valid,
   output logic [CW-1:0]        out_ch,
   output logic signed [DW-1:0] control_out,
   output logic                 sat_flag
);

   localparam int STAGES = 3;
   localparam logic signed [ACCW-1:0] OUT_HI = ACCW'(sat_hi(DW));
   localparam logic signed [ACCW-1:0] OUT_LO = ACCW'(sat_lo(DW));

   logic signed [DW-1:0]   kp [NCH];
   logic signed [DW-1:0]   ki [NCH];
   logic signed [DW-1:0]   kd [NCH];
   logic [DW-1:0]          ilim [NCH];
   logic signed [ACCW-1:0] integ [NCH];
   logic signed [DW-1:0]   last_err [NCH];

   logic [STAGES:1] vld_pipe;
   logic            accept;
   logic            hazard;

   logic [CW-1:0]          s1_ch;
   logic signed [DW-1:0]   s1_err, s1_kp, s1_ki, s1_kd, s1_last;
   logic [DW-1:0]          s1_ilim;
   logic signed [ACCW-1:0] s1_int;
   logic signed [DW:0]     diff;

   logic [CW-1:0]          s2_ch;
   logic signed [DW-1:0]   s2_err;
   logic signed [2*DW-1:0] s2_p, s2_i;
   logic signed [2*DW:0]   s2_d;
   logic [DW-1:0]          s2_ilim;
   logic signed [ACCW-1:0] s2_int;

   logic signed [ACCW-1:0] p_t, i_t, d_t, int_sum, ilim_pos, ilim_neg, new_int, sum;
   logic signed [DW-1:0]   sat_val;
   logic                   int_flag, out_flag;

   // A same-channel sample in S1/S2 has not yet written its state back.
   assign hazard    = (vld_pipe[1] && (s1_ch == in_ch)) || (vld_pipe[2] && (s2_ch == in_ch));
   assign in_ready  = !rst && (!in_valid || !hazard);
   assign accept    = in_valid && in_ready;
   assign out_valid = vld_pipe[STAGES];

   // Configuration, write-back and clears; a clear wins over a same-edge write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            kp[c]       <= '0;
            ki[c]       <= '0;
            kd[c]       <= '0;
            ilim[c]     <= '0;
            integ[c]    <= '0;
            last_err[c] <= '0;
         end
      end else begin
         if (cfg_we) begin
            case (cfg_sel_e'(cfg_sel))
               CFG_KP:   kp[cfg_ch]   <= $signed(cfg_data);
               CFG_KI:   ki[cfg_ch]   <= $signed(cfg_data);
               CFG_KD:   kd[cfg_ch]   <= $signed(cfg_data);
               CFG_ILIM: ilim[cfg_ch] <= cfg_data;
            endcase
         end
         if (vld_pipe[2]) begin
            integ[s2_ch]    <= new_int;
            last_err[s2_ch] <= s2_err;
         end
         for (int c = 0; c < NCH; c++) begin
            if (clr_int[c]) begin
               integ[c]    <= '0;
               last_err[c] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[STAGES-1:1], accept};
   end

   assign diff = (DW+1)'(s1_err) - (DW+1)'(s1_last);

   // Pipeline data carries no reset; the valid bits qualify it.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_ch   <= in_ch;
         s1_err  <= error_in;
         s1_kp   <= kp[in_ch];
         s1_ki   <= ki[in_ch];
         s1_kd   <= kd[in_ch];
         s1_ilim <= ilim[in_ch];
         s1_int  <= clr_int[in_ch] ? '0 : integ[in_ch];
         s1_last <= clr_int[in_ch] ? '0 : last_err[in_ch];
      end
      if (vld_pipe[1]) begin
         s2_ch   <= s1_ch;
         s2_err  <= s1_err;
         s2_p    <= (2*DW)'(s1_err) * (2*DW)'(s1_kp);
         s2_i    <= (2*DW)'(s1_err) * (2*DW)'(s1_ki);
         s2_d    <= (2*DW+1)'(diff) * (2*DW+1)'(s1_kd);
         s2_ilim <= s1_ilim;
         s2_int  <= s1_int;
      end
   end

   assign p_t      = ACCW'(s2_p) >>> GSHIFT;
   assign i_t      = ACCW'(s2_i) >>> GSHIFT;
   assign d_t      = ACCW'(s2_d) >>> GSHIFT;
   assign int_sum  = s2_int + i_t;
   assign ilim_pos = ACCW'(s2_ilim);
   assign ilim_neg = -ilim_pos;

   pid_sat_clamp #(.W(ACCW), .OW(ACCW)) u_int_clamp (
      .val  (int_sum),
      .lo   (ilim_neg),
      .hi   (ilim_pos),
      .res  (new_int),
      .flag (int_flag)
   );

   assign sum = p_t + new_int + d_t;

   pid_sat_clamp #(.W(ACCW), .OW(DW)) u_out_sat (
      .val  (sum),
      .lo   (OUT_LO),
      .hi   (OUT_HI),
      .res  (sat_val),
      .flag (out_flag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_ch      <= '0;
         control_out <= '0;
         sat_flag    <= 1'b0;
      end else if (vld_pipe[2]) begin
         out_ch      <= s2_ch;
         control_out <= sat_val;
         sat_flag    <= int_flag | out_flag;
      end
   end

endmodule
